// File: rtl/muestreo_pkg.sv
// Shared types and constants for the triple-oversampling front end of the majority voter.
// Pure declarations: state encoding, default widths and the unanimous-triple patterns.
package muestreo_pkg;

   typedef logic [1:0] estado_t;

   localparam estado_t IDLE = 2'd0;
   localparam estado_t SA   = 2'd1;
   localparam estado_t SB   = 2'd2;
   localparam estado_t SC   = 2'd3;

   localparam int unsigned CNT_W_DEF = 8;
   localparam int unsigned ABC_W     = 3;

   localparam logic [ABC_W-1:0] ABC_UNANIME0 = 3'b000;
   localparam logic [ABC_W-1:0] ABC_UNANIME1 = 3'b111;

   // A triple is "split" when the three samples disagree, i.e. the line was noisy.
   function automatic logic es_dividido(input logic [ABC_W-1:0] i_triple);
      return (i_triple != ABC_UNANIME0) && (i_triple != ABC_UNANIME1);
   endfunction

endpackage

// File: rtl/registro_hs.sv
// Valid/ready holding register for completed triples. Loads when empty or when the
// current word is consumed on the same edge; otherwise drops the new word and flags overrun.
module registro_hs
   import muestreo_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [ABC_W-1:0] i_data,
   input  logic             i_ready,
   output logic [ABC_W-1:0] o_data,
   output logic             o_valid,
   output logic             o_overrun,
   output logic             o_cargado
);

   logic [ABC_W-1:0] r_data;
   logic             r_valid;
   logic             r_overrun;

   logic             w_libre;
   logic             w_cargar;
   logic             w_consumir;
   logic             w_descartar;

   // Space exists if empty, or if the held word leaves on this very edge.
   assign w_libre     = !r_valid || i_ready;
   assign w_cargar    = i_load && w_libre;
   assign w_consumir  = r_valid && i_ready && !w_cargar;
   assign w_descartar = i_load && !w_libre;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_cargar) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
         end else if (w_consumir) begin
            r_valid <= 1'b0;
         end
         if (w_descartar) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_overrun = r_overrun;
   assign o_cargado = w_cargar;

endmodule

// File: rtl/muestreo_triple.sv
// Oversamples din on three tick strobes into ABC (A first) for the majority voter,
// hands triples over via valid/ready, and counts non-unanimous (split) triples.
module muestreo_triple
   import muestreo_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             tick,
   input  logic             din,
   output logic [ABC_W-1:0] ABC,
   output logic             abc_valid,
   input  logic             abc_ready,
   output logic             overrun,
   output logic [CNT_W-1:0] split_cnt,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   estado_t          r_estado;
   estado_t          w_estado_d;
   logic             r_a;
   logic             r_b;
   logic [CNT_W-1:0] r_split_cnt;

   logic             w_cap_a;
   logic             w_cap_b;
   logic             w_completo;
   logic             w_cargado;
   logic [ABC_W-1:0] w_triple;

   // en low wins over tick in every state and throws away any partial triple.
   always_comb begin
      w_estado_d = r_estado;
      w_cap_a    = 1'b0;
      w_cap_b    = 1'b0;
      w_completo = 1'b0;
      if (!en) begin
         w_estado_d = IDLE;
      end else begin
         case (r_estado)
            IDLE: w_estado_d = SA;
            SA: begin
               if (tick) begin
                  w_cap_a    = 1'b1;
                  w_estado_d = SB;
               end
            end
            SB: begin
               if (tick) begin
                  w_cap_b    = 1'b1;
                  w_estado_d = SC;
               end
            end
            SC: begin
               if (tick) begin
                  w_completo = 1'b1;
                  w_estado_d = SA;
               end
            end
            default: w_estado_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_estado <= IDLE;
         r_a      <= 1'b0;
         r_b      <= 1'b0;
      end else begin
         r_estado <= w_estado_d;
         if (w_cap_a) begin
            r_a <= din;
         end
         if (w_cap_b) begin
            r_b <= din;
         end
      end
   end

   // C is taken straight from din so the triple lands on the edge of the third tick.
   assign w_triple = {r_a, r_b, din};

   registro_hs u_registro_hs (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_completo),
      .i_data    (w_triple),
      .i_ready   (abc_ready),
      .o_data    (ABC),
      .o_valid   (abc_valid),
      .o_overrun (overrun),
      .o_cargado (w_cargado)
   );

   // Only triples actually accepted into the output register are counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_split_cnt <= '0;
      end else if (w_cargado && es_dividido(w_triple) && (r_split_cnt != CNT_MAX)) begin
         r_split_cnt <= r_split_cnt + CNT_W'(1);
      end
   end

   assign split_cnt = r_split_cnt;
   assign busy      = (r_estado != IDLE);

endmodule
